// File: rtl/ex_lsu_if.sv
// rtl/ex_lsu_if.sv - issue, cache, stack scratchpad and writeback bus of the load/store unit
interface ex_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 17
);
  localparam int OP_W  = 4;
  localparam int REG_W = 5;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [XLEN-1:0]   in_x;
  logic [XLEN-1:0]   in_y;
  logic [XLEN-1:0]   in_offset;
  logic [REG_W-1:0]  in_target;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_size;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_done;
  logic [XLEN-1:0]   mem_rdata;

  logic              stk_req;
  logic              stk_we;
  logic [ADDR_W-1:0] stk_addr;
  logic [2:0]        stk_size;
  logic [XLEN-1:0]   stk_wdata;
  logic [XLEN-1:0]   stk_rdata;

  logic              wb_en;
  logic [REG_W-1:0]  wb_target;
  logic [XLEN-1:0]   wb_data;
  logic              misalign;

  modport master (
    input  flush, in_valid, in_op, in_x, in_y, in_offset, in_target,
           mem_gnt, mem_done, mem_rdata, stk_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_size, mem_wdata,
           stk_req, stk_we, stk_addr, stk_size, stk_wdata,
           wb_en, wb_target, wb_data, misalign
  );

  modport slave (
    output flush, in_valid, in_op, in_x, in_y, in_offset, in_target,
           mem_gnt, mem_done, mem_rdata, stk_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_size, mem_wdata,
           stk_req, stk_we, stk_addr, stk_size, stk_wdata,
           wb_en, wb_target, wb_data, misalign
  );
endinterface

// File: rtl/ex_lsu.sv
// rtl/ex_lsu.sv - non-pipelined load/store unit routing to data cache queue or stack scratchpad
module ex_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 17,
  parameter int STK_LSB     = 12,
  parameter bit CHECK_ALIGN = 1
) (
  input  logic     clk,
  input  logic     rst,
  ex_lsu_if.master bus
);
  localparam int REG_W = 5;

  // op[3] = store, op[2] = unsigned load, op[1:0] = log2(bytes)
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  typedef enum logic [2:0] {IDLE, ISSUE, STK, WAIT, DRAIN} state_t;

  state_t            state;
  logic              q_store;
  logic              q_uns;
  logic [2:0]        q_size;
  logic [REG_W-1:0]  q_target;

  logic              op_valid;
  logic              op_store;
  logic [2:0]        op_size;
  logic [ADDR_W-1:0] ea;
  logic              misaligned;
  logic              stk_hit;
  logic              accept;
  logic              wb_fire;
  logic [XLEN-1:0]   wb_src;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [2:0] sz, input logic uns);
    int sh;
    logic [XLEN-1:0] t;
    sh = XLEN - 8 * int'(sz);
    t  = d << sh;
    return uns ? (t >> sh) : XLEN'($signed(t) >>> sh);
  endfunction

  assign bus.in_ready = (state == IDLE) && !bus.flush;

  always_comb begin
    op_store = bus.in_op[3];
    op_size  = 3'd1 << bus.in_op[1:0];
    case (bus.in_op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
    ea = op_store ? ADDR_W'(bus.in_x + bus.in_offset) : ADDR_W'(bus.in_x + bus.in_y);
    misaligned = CHECK_ALIGN && (((op_size == 3'd2) && ea[0]) ||
                                 ((op_size == 3'd4) && (ea[1:0] != 2'b00)));
    stk_hit = &ea[ADDR_W-1:STK_LSB];
    accept  = bus.in_valid && bus.in_ready && op_valid;
    wb_fire = !bus.flush && ((state == WAIT && bus.mem_done) || (state == STK && !q_store));
    wb_src  = (state == STK) ? bus.stk_rdata : bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      q_store       <= 1'b0;
      q_uns         <= 1'b0;
      q_size        <= '0;
      q_target      <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_size  <= '0;
      bus.mem_wdata <= '0;
      bus.stk_req   <= 1'b0;
      bus.stk_we    <= 1'b0;
      bus.stk_addr  <= '0;
      bus.stk_size  <= '0;
      bus.stk_wdata <= '0;
      bus.wb_en     <= 1'b0;
      bus.wb_target <= '0;
      bus.wb_data   <= '0;
      bus.misalign  <= 1'b0;
    end else begin
      bus.stk_req  <= 1'b0;
      bus.stk_we   <= 1'b0;
      bus.misalign <= 1'b0;
      bus.wb_en    <= wb_fire && (q_target != '0);
      if (wb_fire) begin
        bus.wb_target <= q_target;
        bus.wb_data   <= extend(wb_src, q_size, q_uns);
      end
      case (state)
        IDLE: if (accept) begin
          q_store  <= op_store;
          q_uns    <= bus.in_op[2];
          q_size   <= op_size;
          q_target <= bus.in_target;
          if (misaligned) begin
            bus.misalign  <= 1'b1;
            bus.wb_target <= bus.in_target;
          end else if (stk_hit) begin
            bus.stk_req   <= 1'b1;
            bus.stk_we    <= op_store;
            bus.stk_addr  <= ea;
            bus.stk_size  <= op_size;
            bus.stk_wdata <= bus.in_y;
            state         <= STK;
          end else begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= op_store;
            bus.mem_addr  <= ea;
            bus.mem_size  <= op_size;
            bus.mem_wdata <= bus.in_y;
            state         <= ISSUE;
          end
        end
        // A granted op is owned by the cache queue, so flush cannot cancel it;
        // a granted load must still absorb its mem_done.
        ISSUE: if (bus.mem_gnt) begin
          bus.mem_req <= 1'b0;
          if (q_store)        state <= IDLE;
          else if (bus.flush) state <= DRAIN;
          else                state <= WAIT;
        end else if (bus.flush) begin
          bus.mem_req <= 1'b0;
          state       <= IDLE;
        end
        WAIT: if (bus.mem_done)  state <= IDLE;
              else if (bus.flush) state <= DRAIN;
        DRAIN: if (bus.mem_done) state <= IDLE;
        STK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_lsu.sv
// tb/tb_ex_lsu.sv - directed self-checking bench for ex_lsu, aligned and unaligned-pass builds
module tb_ex_lsu;
  localparam logic [3:0] OP_LB  = 4'h0;
  localparam logic [3:0] OP_LH  = 4'h1;
  localparam logic [3:0] OP_LW  = 4'h2;
  localparam logic [3:0] OP_LBU = 4'h4;
  localparam logic [3:0] OP_LHU = 4'h5;
  localparam logic [3:0] OP_SB  = 4'h8;
  localparam logic [3:0] OP_SH  = 4'h9;
  localparam logic [3:0] OP_SW  = 4'hA;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, mem_gnt, mem_done;
  logic [3:0]  in_op;
  logic [31:0] in_x, in_y, in_offset, mem_rdata, stk_rdata;
  logic [4:0]  in_target;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ex_lsu_if #(.XLEN(32), .ADDR_W(17)) bus_a ();
  ex_lsu_if #(.XLEN(32), .ADDR_W(17)) bus_b ();

  assign bus_a.flush = flush;         assign bus_b.flush = flush;
  assign bus_a.in_valid = in_valid;   assign bus_b.in_valid = in_valid;
  assign bus_a.in_op = in_op;         assign bus_b.in_op = in_op;
  assign bus_a.in_x = in_x;           assign bus_b.in_x = in_x;
  assign bus_a.in_y = in_y;           assign bus_b.in_y = in_y;
  assign bus_a.in_offset = in_offset; assign bus_b.in_offset = in_offset;
  assign bus_a.in_target = in_target; assign bus_b.in_target = in_target;
  assign bus_a.mem_gnt = mem_gnt;     assign bus_b.mem_gnt = mem_gnt;
  assign bus_a.mem_done = mem_done;   assign bus_b.mem_done = mem_done;
  assign bus_a.mem_rdata = mem_rdata; assign bus_b.mem_rdata = mem_rdata;
  assign bus_a.stk_rdata = stk_rdata; assign bus_b.stk_rdata = stk_rdata;

  ex_lsu #(.XLEN(32), .ADDR_W(17), .STK_LSB(12), .CHECK_ALIGN(1)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a));
  ex_lsu #(.XLEN(32), .ADDR_W(17), .STK_LSB(12), .CHECK_ALIGN(0)) u_dut_na (
    .clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] off, input logic [4:0] tgt);
    in_op = op; in_x = x; in_y = y; in_offset = off; in_target = tgt; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cache_load(input string tag, input logic [3:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic [4:0] tgt, input logic [31:0] rdata,
                            input logic [16:0] exp_addr, input logic [2:0] exp_size,
                            input logic [31:0] exp_data);
    present(op, x, y, 32'h0, tgt);
    check({tag, "_req"}, bus_a.mem_req, 1);
    check({tag, "_we"}, bus_a.mem_we, 0);
    check({tag, "_addr"}, bus_a.mem_addr, exp_addr);
    check({tag, "_size"}, bus_a.mem_size, exp_size);
    tick();
    check({tag, "_req_held"}, bus_a.mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, bus_a.mem_req, 0);
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0;
    check({tag, "_wb_en"}, bus_a.wb_en, tgt != 5'd0);
    if (tgt != 5'd0) begin
      check({tag, "_wb_data"}, bus_a.wb_data, exp_data);
      check({tag, "_wb_target"}, bus_a.wb_target, tgt);
    end
    tick();
    check({tag, "_wb_pulse"}, bus_a.wb_en, 0);
    check({tag, "_ready"}, bus_a.in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_gnt = 1'b0; mem_done = 1'b0;
    in_op = 4'hF; in_x = '0; in_y = '0; in_offset = '0; in_target = '0;
    mem_rdata = '0; stk_rdata = '0;
    tick(); tick();
    check("rst_ready", bus_a.in_ready, 1);
    check("rst_mem_req", bus_a.mem_req, 0);
    check("rst_stk_req", bus_a.stk_req, 0);
    check("rst_wb_en", bus_a.wb_en, 0);
    check("rst_misalign", bus_a.misalign, 0);
    check("rst_mem_addr", bus_a.mem_addr, 0);
    check("rst_wb_data", bus_a.wb_data, 0);
    rst = 1'b0;
    tick();

    flush = 1'b1; #1;
    check("flush_idle_ready", bus_a.in_ready, 0);
    flush = 1'b0; #1;

    cache_load("lb",  OP_LB,  32'h100, 32'h3, 5'd5, 32'h80, 17'h103, 3'd1, 32'hFFFFFF80);
    cache_load("lbu", OP_LBU, 32'h100, 32'h3, 5'd6, 32'h80, 17'h103, 3'd1, 32'h00000080);
    cache_load("lhu", OP_LHU, 32'h100, 32'h2, 5'd7, 32'h12348001, 17'h102, 3'd2, 32'h00008001);
    cache_load("lh",  OP_LH,  32'h100, 32'h2, 5'd8, 32'h12348001, 17'h102, 3'd2, 32'hFFFF8001);
    cache_load("lw",  OP_LW,  32'h1FFFFFF0, 32'h14, 5'd9, 32'hDEADBEEF, 17'h4, 3'd4, 32'hDEADBEEF);
    cache_load("lw_x0", OP_LW, 32'h200, 32'h0, 5'd0, 32'h12345678, 17'h200, 3'd4, 32'h0);

    // stack store
    present(OP_SW, 32'h1FFF0, 32'hCAFEF00D, 32'h4, 5'd1);
    check("sw_stk_req", bus_a.stk_req, 1);
    check("sw_stk_we", bus_a.stk_we, 1);
    check("sw_stk_addr", bus_a.stk_addr, 17'h1FFF4);
    check("sw_stk_wdata", bus_a.stk_wdata, 32'hCAFEF00D);
    check("sw_mem_req", bus_a.mem_req, 0);
    tick();
    check("sw_stk_pulse", bus_a.stk_req, 0);
    check("sw_wb_en", bus_a.wb_en, 0);
    check("sw_ready", bus_a.in_ready, 1);

    // stack load
    stk_rdata = 32'h00000081;
    present(OP_LB, 32'h1F000, 32'h10, 32'h0, 5'd4);
    check("slb_stk_req", bus_a.stk_req, 1);
    check("slb_stk_we", bus_a.stk_we, 0);
    check("slb_stk_addr", bus_a.stk_addr, 17'h1F010);
    check("slb_wb_early", bus_a.wb_en, 0);
    tick();
    check("slb_wb_en", bus_a.wb_en, 1);
    check("slb_wb_data", bus_a.wb_data, 32'hFFFFFF81);
    tick();
    check("slb_wb_pulse", bus_a.wb_en, 0);

    // misaligned SH: trapped by u_dut, passed through by u_dut_na
    present(OP_SH, 32'h200, 32'hBEEF, 32'h1, 5'd11);
    check("sh_misalign", bus_a.misalign, 1);
    check("sh_mis_target", bus_a.wb_target, 5'd11);
    check("sh_mis_noreq", bus_a.mem_req, 0);
    check("sh_na_req", bus_b.mem_req, 1);
    check("sh_na_we", bus_b.mem_we, 1);
    check("sh_na_addr", bus_b.mem_addr, 17'h201);
    check("sh_na_size", bus_b.mem_size, 3'd2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sh_na_req_held", bus_b.mem_req, 1);
      check("sh_na_addr_held", bus_b.mem_addr, 17'h201);
    end
    check("sh_misalign_pulse", bus_a.misalign, 0);
    check("sh_mis_ready", bus_a.in_ready, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sh_na_req_drop", bus_b.mem_req, 0);
    check("sh_na_ready", bus_b.in_ready, 1);

    // flush in WAIT, late mem_done
    present(OP_LW, 32'h300, 32'h0, 32'h0, 5'd3);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("drain_ready0", bus_a.in_ready, 0);
    tick();
    tick();
    check("drain_ready1", bus_a.in_ready, 0);
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_done = 1'b0;
    check("drain_wb_en", bus_a.wb_en, 0);
    check("drain_ready_after", bus_a.in_ready, 1);
    tick();
    check("drain_wb_en_late", bus_a.wb_en, 0);

    // flush in ISSUE before grant, then immediate new op
    present(OP_SB, 32'h400, 32'h5A, 32'h0, 5'd2);
    check("fi_req", bus_a.mem_req, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check("fi_req_drop", bus_a.mem_req, 0);
    check("fi_ready", bus_a.in_ready, 1);
    cache_load("fi_next", OP_LBU, 32'h500, 32'h1, 5'd12, 32'hFF, 17'h501, 3'd1, 32'hFF);

    // reset held mid-ISSUE
    present(OP_LW, 32'h600, 32'h0, 32'h0, 5'd13);
    check("rmid_req", bus_a.mem_req, 1);
    rst = 1'b1; #1;
    check("rmid_async", bus_a.mem_req, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rmid_mem_req", bus_a.mem_req, 0);
    check("rmid_wb_en", bus_a.wb_en, 0);
    check("rmid_ready", bus_a.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
